// File: rtl/divider32_pkg.sv
// divider32_pkg: op encoding, FSM states and sizing constants shared by the divider32 files
package divider32_pkg;
  localparam int XLEN = 32;
  localparam int DIV_ITER = 32;
  typedef enum logic [1:0] {OP_DIV = 2'b00, OP_DIVU = 2'b01, OP_REM = 2'b10, OP_REMU = 2'b11} op_e;
  typedef enum logic [1:0] {IDLE = 2'b00, CALC = 2'b01, DONE = 2'b10} state_e;
endpackage

// File: rtl/divider32_subtractor32.sv
// subtractor32: a - b as a + ~b + 1 on fulladder32; borrow_o is the inverted carry
module subtractor32 (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] diff_o,
  output logic        borrow_o
);
  logic carry;
  fulladder32 u_add (.a_i(a_i), .b_i(~b_i), .carry_i(1'b1), .sum_o(diff_o), .carry_o(carry));
  assign borrow_o = ~carry;
endmodule

// File: rtl/fulladder32.sv
// fulladder32: 32-bit ripple adder with carry in and carry out
module fulladder32 (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        carry_i,
  output logic [31:0] sum_o,
  output logic        carry_o
);
  assign {carry_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {32'd0, carry_i};
endmodule

// File: rtl/divider32.sv
// divider32: 32-cycle restoring divider with valid/ready handshakes.
// DIVIDER32_SIGNED_EN enables signed DIV/REM; otherwise op_i[0] is ignored.
module divider32
  import divider32_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [1:0]      op_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic            res_valid_o,
  input  logic            res_ready_i,
  output logic [XLEN-1:0] result_o,
  output logic            busy_o
);
  state_e          state_q;
  logic [4:0]      cnt_q;
  logic            fix_q, rsel_q, take, borrow, dz, ovf, a_neg, b_neg;
  logic [XLEN-1:0] rem_q, quo_q, dvs_q, result_q, shl, diff, rem_d, quo_d, a_mag, b_mag, q_fix, r_fix;
  assign shl = {rem_q[XLEN-2:0], quo_q[XLEN-1]};
  subtractor32 u_sub (.a_i(shl), .b_i(dvs_q), .diff_o(diff), .borrow_o(borrow));
  // bit shifted out of rem makes the 33-bit trial non-negative regardless of borrow
  assign take  = rem_q[XLEN-1] | ~borrow;
  assign rem_d = take ? diff : shl;
  assign quo_d = {quo_q[XLEN-2:0], take};
  assign dz    = divisor_i == '0;
`ifdef DIVIDER32_SIGNED_EN
  logic qneg_q, rneg_q;
  assign a_neg = ~op_i[0] & dividend_i[XLEN-1];
  assign b_neg = ~op_i[0] & divisor_i[XLEN-1];
  assign ovf   = ~op_i[0] & (dividend_i == 32'h8000_0000) & (&divisor_i);
  assign q_fix = qneg_q ? -quo_q : quo_q;
  assign r_fix = rneg_q ? -rem_q : rem_q;
`else
  assign a_neg = 1'b0;
  assign b_neg = 1'b0;
  assign ovf   = 1'b0;
  assign q_fix = quo_q;
  assign r_fix = rem_q;
`endif
  assign a_mag = a_neg ? -dividend_i : dividend_i;
  assign b_mag = b_neg ? -divisor_i : divisor_i;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      fix_q    <= 1'b0;
      rsel_q   <= 1'b0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      result_q <= '0;
`ifdef DIVIDER32_SIGNED_EN
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: if (req_valid_i) begin
          rsel_q <= op_i[1];
          if (dz || ovf) begin
            state_q  <= DONE;
            result_q <= dz ? (op_i[1] ? dividend_i : '1) : (op_i[1] ? '0 : 32'h8000_0000);
          end else begin
            state_q <= CALC;
            cnt_q   <= '0;
            fix_q   <= 1'b0;
            rem_q   <= '0;
            quo_q   <= a_mag;
            dvs_q   <= b_mag;
`ifdef DIVIDER32_SIGNED_EN
            qneg_q  <= a_neg ^ b_neg;
            rneg_q  <= a_neg;
`endif
          end
        end
        CALC: if (fix_q) begin
          state_q  <= DONE;
          fix_q    <= 1'b0;
          result_q <= rsel_q ? r_fix : q_fix;
        end else begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          cnt_q <= cnt_q + 5'd1;
          fix_q <= cnt_q == 5'(DIV_ITER - 1);
        end
        DONE: if (res_ready_i) begin
          state_q  <= IDLE;
          result_q <= '0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign req_ready_o = state_q == IDLE;
  assign res_valid_o = state_q == DONE;
  assign busy_o      = state_q != IDLE;
  assign result_o    = result_q;
endmodule

// File: tb/tb_divider32.sv
// tb_divider32: directed vector table plus backpressure and mid-CALC reset sequences
module tb_divider32;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        req_valid = 1'b0, res_ready = 1'b0;
  logic        req_ready, res_valid, busy;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0, b = '0, result;
  int n_cmp = 0, n_bad = 0;

  divider32 dut (
    .clk_i(clk), .rst_ni(rst_n), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .op_i(op), .dividend_i(a), .divisor_i(b), .res_valid_o(res_valid),
    .res_ready_i(res_ready), .result_o(result), .busy_o(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a, b, res;
    int          lat;
  } vec_t;
  vec_t v[17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic accept(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    op = o; a = x; b = y; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    op = 2'($urandom); a = $urandom; b = $urandom;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
      if (lat == 5 && !res_valid) chk("result_zero_in_calc", result, 32'd0);
    end while (!res_valid && lat < 100);
  endtask

  task automatic drain;
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
  endtask

  initial begin
    int lat;
    logic [31:0] held;
    v[0]  = '{2'b01, 32'd100,       32'd7,          32'd14,         33};
    v[1]  = '{2'b11, 32'd100,       32'd7,          32'd2,          33};
    v[2]  = '{2'b01, 32'h1234_5678, 32'd0,          32'hFFFF_FFFF,  1};
    v[3]  = '{2'b11, 32'h1234_5678, 32'd0,          32'h1234_5678,  1};
    v[4]  = '{2'b01, 32'hFFFF_FFFF, 32'd1,          32'hFFFF_FFFF,  33};
    v[5]  = '{2'b11, 32'hFFFF_FFFF, 32'd10,         32'd5,          33};
    v[6]  = '{2'b01, 32'd7,         32'd100,        32'd0,          33};
    v[7]  = '{2'b11, 32'd7,         32'd100,        32'd7,          33};
    v[8]  = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF,  32'd1,          33};
`ifdef DIVIDER32_SIGNED_EN
    v[9]  = '{2'b00, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFD,  33};
    v[10] = '{2'b10, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF,  33};
    v[11] = '{2'b00, 32'h8000_0000, 32'hFFFF_FFFF,  32'h8000_0000,  1};
    v[12] = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF,  32'd0,          1};
    v[13] = '{2'b00, 32'd100,       32'hFFFF_FFF9,  32'hFFFF_FFF2,  33};
    v[14] = '{2'b10, 32'd100,       32'hFFFF_FFF9,  32'd2,          33};
`else
    v[9]  = '{2'b00, 32'hFFFF_FFF9, 32'd2,          32'h7FFF_FFFC,  33};
    v[10] = '{2'b10, 32'hFFFF_FFF9, 32'd2,          32'd1,          33};
    v[11] = '{2'b00, 32'h8000_0000, 32'hFFFF_FFFF,  32'd0,          33};
    v[12] = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF,  32'h8000_0000,  33};
    v[13] = '{2'b00, 32'd100,       32'hFFFF_FFF9,  32'd0,          33};
    v[14] = '{2'b10, 32'd100,       32'hFFFF_FFF9,  32'd100,        33};
`endif
    v[15] = '{2'b00, 32'd5,         32'd0,          32'hFFFF_FFFF,  1};
    v[16] = '{2'b10, 32'hFFFF_FFFB, 32'd0,          32'hFFFF_FFFB,  1};

    #12 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("reset_res_valid", 32'(res_valid), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_result", result, 32'd0);
    chk("reset_req_ready", 32'(req_ready), 32'd1);

    for (int i = 0; i < 17; i++) begin
      chk($sformatf("v%0d_req_ready", i), 32'(req_ready), 32'd1);
      accept(v[i].op, v[i].a, v[i].b);
      wait_valid(lat);
      chk($sformatf("v%0d_latency", i), 32'(lat), 32'(v[i].lat));
      chk($sformatf("v%0d_result", i), result, v[i].res);
      drain;
      chk($sformatf("v%0d_idle_result", i), result, 32'd0);
      chk($sformatf("v%0d_idle_busy", i), 32'(busy), 32'd0);
    end

    // backpressure in DONE with a competing request held high
    accept(2'b01, 32'd100, 32'd7);
    wait_valid(lat);
    held = result;
    chk("bp_first", held, 32'd14);
    op = 2'b01; a = 32'd9; b = 32'd3; req_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("bp_hold_result", result, held);
      chk("bp_req_ready", 32'(req_ready), 32'd0);
      chk("bp_res_valid", 32'(res_valid), 32'd1);
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    chk("bp_back_idle", 32'(busy), 32'd0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("bp_next_accept", 32'(busy), 32'd1);
    wait_valid(lat);
    chk("bp_next_latency", 32'(lat), 32'd33);
    chk("bp_next_result", result, 32'd3);
    drain;

    // reset in the middle of CALC
    accept(2'b01, 32'd1000, 32'd10);
    repeat (16) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_result", result, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    lat = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (res_valid || busy) lat++;
    end
    chk("rst_no_result", 32'(lat), 32'd0);
    accept(2'b01, 32'd1000, 32'd10);
    wait_valid(lat);
    chk("rst_fresh_latency", 32'(lat), 32'd33);
    chk("rst_fresh_result", result, 32'd100);
    drain;

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/divider32.md
DIVIDER32 -- requirements
Module: divider32

Interface
REQ-001 clk_i  input  1  single clock; all state updates on rising edge.
REQ-002 rst_ni  input  1  reset, asynchronous assert, active-low.
REQ-003 req_valid_i  input  1  request offered.
REQ-004 req_ready_o  output  1  request accepted when both high at clock edge.
REQ-005 op_i  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU (RISC-V M encoding order).
REQ-006 dividend_i  input  32  dividend, sampled at request handshake only.
REQ-007 divisor_i  input  32  divisor, sampled at request handshake only.
REQ-008 res_valid_o  output  1  result available.
REQ-009 res_ready_i  input  1  result consumed when both high at clock edge.
REQ-010 result_o  output  32  quotient (DIV/DIVU) or remainder (REM/REMU).
REQ-011 busy_o  output  1  high in any state other than IDLE.

Function
REQ-012 FSM states SHALL be IDLE, CALC, DONE; req_ready_o SHALL equal (state==IDLE), res_valid_o SHALL equal (state==DONE).
REQ-013 IDLE->CALC on request handshake, except divisor==0 or signed overflow, which SHALL go IDLE->DONE directly (fast path, result valid next cycle).
REQ-014 CALC SHALL run exactly 32 restoring iterations, one quotient bit per cycle, MSB first, via a 5-bit iteration counter; CALC->DONE after the 32nd iteration.
REQ-015 Normal-path latency: res_valid_o SHALL rise on the 33rd rising edge after the accepting edge.
REQ-016 Each iteration: shift {rem,quo} left 1; trial = rem - divisor (33-bit, borrow-aware); if no borrow, rem=trial and quo[0]=1, else restore.
REQ-017 Signed ops: operate on magnitudes; quotient negated if operand signs differ; remainder takes dividend sign; fixup applied before DONE.
REQ-018 Divide by zero: quotient 0xFFFFFFFF (all ops), remainder = dividend (all ops).
REQ-019 Signed overflow (DIV/REM, dividend 0x80000000, divisor 0xFFFFFFFF): quotient 0x80000000, remainder 0.
REQ-020 DONE->IDLE on result handshake; result_o SHALL hold stable while res_valid_o high and res_ready_i low.
REQ-021 No request SHALL be accepted in CALC or DONE; same-cycle res handshake in DONE does not permit request acceptance that cycle (req_ready_o low).
REQ-022 result_o SHALL be 0 whenever state is not DONE.
REQ-023 Operand changes on dividend_i/divisor_i/op_i after handshake SHALL NOT affect the computation.

Reset
REQ-024 rst_ni low SHALL immediately force state IDLE, counter 0, all datapath registers 0, res_valid_o 0, busy_o 0, result_o 0, req_ready_o 1 (once released).
REQ-025 Reset asserted mid-CALC or in DONE SHALL abort the operation with no result produced.

Configuration
REQ-026 Macro DIVIDER32_SIGNED_EN defined: DIV/REM perform signed division per REQ-017/REQ-019.
REQ-027 Macro undefined: op_i[0] ignored, DIV treated as DIVU and REM as REMU; no sign fixup or overflow fast path logic SHALL be synthesized.

Structure
REQ-028 Shared package SHALL hold the op_i encoding enum, FSM state enum, and constants XLEN=32 and DIV_ITER=32.
REQ-029 One sub-module subtractor32 (32-bit a - b with borrow out, built on the existing fulladder32 with inverted b and carry_i=1) SHALL provide the trial subtraction.

Verification
REQ-030 DIVU 100 / 7 -> result_o 14, res_valid_o rises 33 edges after accept; REMU same operands -> 2.
REQ-031 DIV -7 / 2 (0xFFFFFFF9, 2) -> 0xFFFFFFFD (-3); REM same -> 0xFFFFFFFF (-1) (SIGNED_EN defined).
REQ-032 DIVU 0x12345678 / 0 -> 0xFFFFFFFF one cycle after accept; REMU -> 0x12345678.
REQ-033 DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM -> 0; without macro DIV gives 0x00000000 after 33 cycles.
REQ-034 Hold res_ready_i low 10 cycles in DONE with req_valid_i high -> result_o stable, req_ready_o low, no second accept; then handshake -> IDLE, next request accepted.
REQ-035 Pull rst_ni low at iteration 16 of CALC -> outputs reset immediately, res_valid_o never asserts; fresh request after release computes correctly.
